spi_slave_rx: RTL and testbench

- SPI slave endpoint that sits directly downstream of the simple_spi master core on the bench/SoC side.
- Consumes the master's sck/mosi/ss outputs and oversamples them on the system clock.
- Deserialises MOSI into bytes delivered over a valid/ready interface, and serialises a 1-entry TX holding register onto MISO.
- Supports all four CPOL/CPHA modes.

---
 rtl/spi_slave_rx.sv | 196 +++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI slave endpoint: oversamples sck/mosi/ss on clk_i, supports all four CPOL/CPHA modes,
// delivers received bytes over valid/ready and serialises a 1-entry TX holding register onto MISO.
module spi_slave_rx #(
   parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sck_i,
   input  logic       mosi_i,
   input  logic       ss_n_i,
   output logic       miso_o,
   output logic       miso_oe_o,
   input  logic       cpol_i,
   input  logic       cpha_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       busy_o,
   output logic       ovr_o,
   output logic       udr_o,
   output logic       abort_o,
   input  logic       flag_clr_i
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   logic       r_sck_s1, r_sck_s2, r_sck_d;
   logic       r_mosi_s1, r_mosi_s2;
   logic       r_ss_s1, r_ss_s2, r_ss_d;

   state_t     r_state;
   logic       r_cpol, r_cpha;
   logic [2:0] r_bcnt;
   logic       r_pend;
   logic [7:0] r_rx_sh;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic [7:0] r_tx_sh;
   logic [7:0] r_tx_hold;
   logic       r_tx_empty;
   logic       r_busy, r_oe, r_ovr, r_udr, r_abort;

   logic       w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;
   logic       w_active, w_start, w_sample, w_shift, w_load, w_done, w_tx_wr;
   logic [7:0] w_rx_byte;

   assign w_sck_rise = r_sck_s2 & ~r_sck_d;
   assign w_sck_fall = ~r_sck_s2 & r_sck_d;
   assign w_ss_fall  = r_ss_d & ~r_ss_s2;
   assign w_ss_rise  = ~r_ss_d & r_ss_s2;

   // Edges are only honoured while selected; the deselect cycle itself ends the frame instead.
   assign w_active  = (r_state == S_ACTIVE) & ~w_ss_rise;
   assign w_start   = (r_state == S_IDLE) & w_ss_fall;
   assign w_sample  = w_active & ((r_cpol ^ r_cpha) ? w_sck_fall : w_sck_rise);
   assign w_shift   = w_active & ((r_cpol ^ r_cpha) ? w_sck_rise : w_sck_fall);
   // r_pend marks "next shift edge must load a fresh byte instead of shifting".
   assign w_load    = (w_start & ~cpha_i) | (w_shift & r_pend);
   assign w_done    = w_sample & (r_bcnt == 3'd7);
   assign w_rx_byte = {r_rx_sh[6:0], r_mosi_s2};
   assign w_tx_wr   = tx_valid_i & r_tx_empty;

   // Two-flop synchronisers plus one delay stage for edge detection.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sck_s1  <= 1'b0;
         r_sck_s2  <= 1'b0;
         r_sck_d   <= 1'b0;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
         r_ss_s1   <= 1'b1;
         r_ss_s2   <= 1'b1;
         r_ss_d    <= 1'b1;
      end else begin
         r_sck_s1  <= sck_i;
         r_sck_s2  <= r_sck_s1;
         r_sck_d   <= r_sck_s2;
         r_mosi_s1 <= mosi_i;
         r_mosi_s2 <= r_mosi_s1;
         r_ss_s1   <= ss_n_i;
         r_ss_s2   <= r_ss_s1;
         r_ss_d    <= r_ss_s2;
      end
   end

   // Frame FSM, shift registers, RX delivery, TX holding register and sticky flags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_cpol     <= 1'b0;
         r_cpha     <= 1'b0;
         r_bcnt     <= 3'd0;
         r_pend     <= 1'b0;
         r_rx_sh    <= 8'h00;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_tx_sh    <= 8'h00;
         r_tx_hold  <= 8'h00;
         r_tx_empty <= 1'b1;
         r_busy     <= 1'b0;
         r_oe       <= 1'b0;
         r_ovr      <= 1'b0;
         r_udr      <= 1'b0;
         r_abort    <= 1'b0;
      end else begin
         r_abort <= 1'b0;
         if (flag_clr_i) begin
            r_ovr <= 1'b0;
            r_udr <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_ss_fall) begin
                  r_state <= S_ACTIVE;
                  r_cpol  <= cpol_i;
                  r_cpha  <= cpha_i;
                  r_bcnt  <= 3'd0;
                  r_busy  <= 1'b1;
                  r_oe    <= 1'b1;
                  r_pend  <= cpha_i;
               end
            end
            S_ACTIVE: begin
               if (w_ss_rise) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_oe    <= 1'b0;
                  r_abort <= (r_bcnt != 3'd0);
                  r_bcnt  <= 3'd0;
                  r_pend  <= 1'b0;
               end else begin
                  if (w_sample) begin
                     r_rx_sh <= w_rx_byte;
                     r_bcnt  <= r_bcnt + 3'd1;
                     if (r_bcnt == 3'd7) begin
                        r_pend <= 1'b1;
                     end
                  end
                  if (w_shift) begin
                     if (r_pend) begin
                        r_pend <= 1'b0;
                     end else begin
                        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                     end
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_done) begin
            if (!r_rx_valid || rx_ready_i) begin
               r_rx_data  <= w_rx_byte;
               r_rx_valid <= 1'b1;
            end else begin
               r_ovr <= 1'b1;
            end
         end else if (r_rx_valid && rx_ready_i) begin
            r_rx_valid <= 1'b0;
         end

         // A load from an empty register uses DEFAULT_TX even if a write lands in the same cycle.
         if (w_load) begin
            if (!r_tx_empty) begin
               r_tx_sh    <= r_tx_hold;
               r_tx_empty <= 1'b1;
            end else begin
               r_tx_sh <= DEFAULT_TX;
               r_udr   <= 1'b1;
            end
         end
         if (w_tx_wr) begin
            r_tx_hold  <= tx_data_i;
            r_tx_empty <= 1'b0;
         end
      end
   end

   assign miso_o     = r_tx_sh[7];
   assign miso_oe_o  = r_oe;
   assign rx_data_o  = r_rx_data;
   assign rx_valid_o = r_rx_valid;
   assign tx_ready_o = r_tx_empty;
   assign busy_o     = r_busy;
   assign ovr_o      = r_ovr;
   assign udr_o      = r_udr;
   assign abort_o    = r_abort;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: a behavioural SPI master drives frames in all modes while a
// scoreboard queue holds the bytes the consumer side must see.
module tb_spi_slave_rx;

   localparam int H = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sck = 1'b0;
   logic       mosi = 1'b0;
   logic       ss_n = 1'b1;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic       rx_ready = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       flag_clr = 1'b0;

   logic       miso, miso_oe, rx_valid, tx_ready, busy, ovr, udr, abort_p;
   logic [7:0] rx_data;

   int         n_checks = 0;
   int         n_fail = 0;
   int         abort_cnt = 0;
   logic [7:0] exp_q[$];
   logic       snap_valid, snap_udr;
   logic [7:0] m0, m1;
   int         a0;

   spi_slave_rx #(.DEFAULT_TX(8'hFF)) dut (
      .clk_i(clk), .rst_i(rst), .sck_i(sck), .mosi_i(mosi), .ss_n_i(ss_n),
      .miso_o(miso), .miso_oe_o(miso_oe), .cpol_i(cpol), .cpha_i(cpha),
      .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
      .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
      .busy_o(busy), .ovr_o(ovr), .udr_o(udr), .abort_o(abort_p),
      .flag_clr_i(flag_clr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // consumer-side scoreboard: every accepted byte must match the oldest expected one
   always @(negedge clk) begin
      if (!rst && rx_valid && rx_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_underflow", exp_q.size(), 1);
         end else begin
            check_eq("rx_byte", rx_data, exp_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (abort_p) abort_cnt++;
   end

   task automatic tx_write(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      clks(1);
      tx_valid = 1'b0;
   endtask

   task automatic flag_pulse();
      flag_clr = 1'b1;
      clks(1);
      flag_clr = 1'b0;
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      clks(3);
      rx_ready = 1'b0;
      check_eq("sb_empty", exp_q.size(), 0);
   endtask

   // SPI master: nbytes bytes (or stop_bits bits then deselect), returns bytes seen on MISO
   task automatic spi_frame(input logic [1:0] mode, input int nbytes, input logic [7:0] d0,
                            input logic [7:0] d1, input int stop_bits, input bit pulse_rdy,
                            output logic [7:0] r0, output logic [7:0] r1);
      logic [15:0] tb_bits;
      logic [15:0] rb_bits;
      logic        pol, pha;
      int          total;
      tb_bits = {d0, d1};
      rb_bits = 16'h0000;
      pol     = mode[1];
      pha     = mode[0];
      total   = (stop_bits > 0) ? stop_bits : nbytes * 8;
      cpol    = pol;
      cpha    = pha;
      sck     = pol;
      mosi    = tb_bits[15];
      clks(4);
      ss_n = 1'b0;
      clks(3);
      check_eq("busy_rise", busy, 1);
      clks(H - 3);
      for (int k = 0; k < total; k++) begin
         sck = ~pol;
         if (pha) mosi = tb_bits[15-k];
         else     rb_bits[15-k] = miso;
         if (pulse_rdy && k == total - 1) begin
            clks(2);
            rx_ready = 1'b1;
            clks(1);
            rx_ready = 1'b0;
            clks(3);
         end else begin
            clks(6);
         end
         if (k == total - 1) begin
            snap_valid = rx_valid;
            snap_udr   = udr;
         end
         clks(H - 6);
         sck = pol;
         if (pha) rb_bits[15-k] = miso;
         else if (k < 15) mosi = tb_bits[14-k];
         clks(H);
      end
      ss_n = 1'b1;
      clks(3);
      check_eq("busy_fall", busy, 0);
      clks(H);
      r0 = rb_bits[15:8];
      r1 = rb_bits[7:0];
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_rx_valid", rx_valid, 0);
      check_eq("rst_rx_data", rx_data, 0);
      check_eq("rst_miso", miso, 0);
      check_eq("rst_miso_oe", miso_oe, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ovr", ovr, 0);
      check_eq("rst_udr", udr, 0);
      check_eq("rst_abort", abort_p, 0);
      check_eq("rst_tx_ready", tx_ready, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      clks(3);
      check_reset_outputs();
      rst = 1'b0;
      clks(2);

      // mode 0, preloaded A5, master sends 3C
      tx_write(8'hA5);
      check_eq("tx_ready_full", tx_ready, 0);
      exp_q.push_back(8'h3C);
      spi_frame(2'd0, 1, 8'h3C, 8'h00, 0, 1'b0, m0, m1);
      check_eq("m0_miso", m0, 8'hA5);
      check_eq("m0_rx_latency", snap_valid, 1);
      check_eq("m0_udr", snap_udr, 0);
      drain();

      for (int md = 1; md < 4; md++) begin
         flag_pulse();
         tx_write(8'h7E);
         exp_q.push_back(8'h81);
         spi_frame(md[1:0], 1, 8'h81, 8'h00, 0, 1'b0, m0, m1);
         check_eq($sformatf("mode%0d_miso", md), m0, 8'h7E);
         drain();
      end

      // two bytes, TX empty, consumer stalled: second byte overruns
      flag_pulse();
      check_eq("two_tx_empty", tx_ready, 1);
      exp_q.push_back(8'h5A);
      spi_frame(2'd0, 2, 8'h5A, 8'hC3, 0, 1'b0, m0, m1);
      check_eq("two_miso0", m0, 8'hFF);
      check_eq("two_miso1", m1, 8'hFF);
      check_eq("two_ovr", ovr, 1);
      check_eq("two_udr", udr, 1);
      flag_pulse();
      check_eq("clr_ovr", ovr, 0);
      check_eq("clr_udr", udr, 0);
      drain();

      // deselect after 5 bits
      a0 = abort_cnt;
      rx_ready = 1'b1;
      spi_frame(2'd0, 1, 8'hF0, 8'h00, 5, 1'b0, m0, m1);
      check_eq("abort_pulses", abort_cnt - a0, 1);
      check_eq("abort_rx_valid", rx_valid, 0);
      exp_q.push_back(8'h96);
      spi_frame(2'd0, 1, 8'h96, 8'h00, 0, 1'b0, m0, m1);
      check_eq("after_abort_pulses", abort_cnt - a0, 1);
      drain();

      // consume exactly in the completion cycle of the next byte
      flag_pulse();
      exp_q.push_back(8'h6B);
      exp_q.push_back(8'hD4);
      spi_frame(2'd0, 2, 8'h6B, 8'hD4, 0, 1'b1, m0, m1);
      check_eq("simul_valid", rx_valid, 1);
      check_eq("simul_ovr", ovr, 0);
      check_eq("simul_pending", exp_q.size(), 1);
      drain();

      // reset in the middle of a byte
      spi_frame(2'd0, 1, 8'h42, 8'h00, 0, 1'b0, m0, m1);
      check_eq("pre_rst_valid", rx_valid, 1);
      tx_write(8'hE7);
      check_eq("pre_rst_tx_ready", tx_ready, 0);
      a0 = abort_cnt;
      cpol = 1'b0;
      cpha = 1'b0;
      ss_n = 1'b0;
      clks(H);
      repeat (3) begin
         sck = 1'b1;
         clks(H);
         sck = 1'b0;
         clks(H);
      end
      rst = 1'b1;
      clks(1);
      check_reset_outputs();
      rst  = 1'b0;
      ss_n = 1'b1;
      clks(2 * H);
      check_eq("rst_no_abort", abort_cnt - a0, 0);
      rx_ready = 1'b1;
      exp_q.push_back(8'h55);
      spi_frame(2'd0, 1, 8'h55, 8'h00, 0, 1'b0, m0, m1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
